uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Buffers bytes from the UART receiver's done/out/err outputs into a circular FIFO for the bus-side consumer. Each entry carries a frame-error tag. Provides a valid/ready read port, a sticky overrun flag, a level-threshold interrupt and a character-timeout interrupt. The timeout counts receiver s_tick pulses. Sits directly downstream of the UART receiver, on the same clock.

Parameters:
DEPTH, 16, number of entries; power of two, ≥2
WIDTH, 8, data bits per entry (the entry stores WIDTH+1 bits including the error tag)
THRESH, 8, level at or above which thresh_irq asserts; 1..DEPTH
TIMEOUT_TICKS, 640, idle s_tick count before timeout_irq (4 character times at 16x oversampling)

Ports:
clk  in  1  system clock
rstN  in  1  reset: synchronous, active-high despite the name
rx_done  in  1  one-cycle pulse from receiver; push rx_data/rx_err
rx_data  in  WIDTH  received byte, valid when rx_done=1
rx_err  in  1  frame error for this byte, valid when rx_done=1
s_tick  in  1  oversample tick shared with the receiver
rd_ready  in  1  consumer accepts head entry
clr_ovr  in  1  clears the overrun sticky flag
flush  in  1  synchronous empty: pointers, count and timeout counter go to 0
rd_valid  out  1  FIFO non-empty
rd_data  out  WIDTH  head entry data
rd_err  out  1  head entry frame-error tag
count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
full  out  1  count==DEPTH
overrun  out  1  sticky: a byte was dropped
thresh_irq  out  1  count≥THRESH
timeout_irq  out  1  non-empty and idle for TIMEOUT_TICKS ticks

Behaviour:
- One clock clk; reset rstN is synchronous and active-high.
- Reset: wr_ptr=rd_ptr=0, count=0, overrun=0, timeout counter=0, timeout_irq=0. Storage array is not reset.
- After reset: rd_valid=0, full=0, thresh_irq=0, rd_data and rd_err are don't-care.
- Show-ahead read: rd_data and rd_err are driven combinationally from mem[rd_ptr]; rd_valid=(count!=0).
- Pop when rd_valid&&rd_ready: rd_ptr+1 wraps mod DEPTH; count−1 at the next edge.
- Push when rx_done and (not full, or a pop occurs in the same cycle):
  - mem[wr_ptr]←{rx_err,rx_data}; wr_ptr+1 wraps mod DEPTH.
  - A pushed byte is visible on rd_valid the cycle after the push edge (1-cycle latency).
- Simultaneous push and pop: count unchanged.
  - When full: both succeed; no overrun.
  - When empty: rd_valid=0, so no pop; push succeeds.
- rx_done while full with no pop: byte dropped, storage and pointers untouched, overrun←1.
- overrun clears only on clr_ovr. If clr_ovr and a new drop occur in the same cycle, overrun stays 1 (set wins).
- flush has priority over push and pop in the same cycle: the result is empty and the pushed byte is discarded. flush does not clear overrun.
- count, full and thresh_irq are registered and consistent with the pointers every cycle. Pointers use an extra wrap bit or an independent counter; full/empty must never alias.
- Timeout counter, width $clog2(TIMEOUT_TICKS+1):
  - Reset to 0 on push, pop, flush, or when count==0.
  - Otherwise increments on each s_tick and saturates at TIMEOUT_TICKS.
  - timeout_irq = (counter==TIMEOUT_TICKS) && count!=0, registered.
  - timeout_irq deasserts the cycle after any push or pop.
- Reset mid-operation (rstN=1 in any cycle) overrides everything; outputs reach reset values at the next edge.

Decomposition:
- definitions_pkg gains:
  - RX_FIFO_DEPTH=16, RX_FIFO_THRESH=8, RX_TIMEOUT_TICKS=640
  - typedef rx_entry_t: packed struct {logic err; logic [7:0] data;}
- Existing OVERSAMPLE_RATE is reused to document TIMEOUT_TICKS = 40*OVERSAMPLE_RATE.
- One natural sub-module: rx_fifo_timeout (saturating idle-tick counter plus irq register). The FIFO core stays in uart_rx_fifo.

Test Plan:
- Reset, then push 0x55 (rx_err=0): next cycle rd_valid=1, rd_data=0x55, rd_err=0, count=1. Pop: rd_valid=0, count=0.
- Push 0x00..0x0F with rd_ready=0: full=1, count=16, thresh_irq=1 from the 8th push onward. Drain 16 times: data returns in order 0x00..0x0F; the pointer wrap is exercised by a second fill.
- Fill to 16, push 0xAA with no pop: overrun=1, count=16, head still 0x00. clr_ovr: overrun=0.
- Full FIFO, push 0xBB with a simultaneous pop: count stays 16, no overrun, 0xBB is delivered last.
- Push 0x3C with rx_err=1: rd_err=1 with rd_data=0x3C. Hold with no push/pop for 640 s_ticks: timeout_irq=1 on the 640th tick's following cycle. Pop: timeout_irq=0 next cycle.
- Mid-fill (count=5), assert flush together with rx_done: count=0, rd_valid=0, overrun unchanged. Repeat with rstN=1 instead: all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive FIFO.
package uart_rx_fifo_pkg;

    localparam int OVERSAMPLE_RATE  = 16;
    localparam int RX_FIFO_DEPTH    = 16;
    localparam int RX_FIFO_WIDTH    = 8;
    localparam int RX_FIFO_THRESH   = 8;
    // Four character times (10 bits each) at the receiver oversample rate.
    localparam int RX_TIMEOUT_TICKS = 40 * OVERSAMPLE_RATE;

    // One stored entry: frame-error tag above the received byte.
    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_entry_t;

    // Occupancy needs one bit more than the pointer to represent "full".
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side push signals plus the bus-side read port and status flags.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = RX_FIFO_WIDTH,
    parameter int DEPTH = RX_FIFO_DEPTH
);
    logic                          rx_done;
    logic [WIDTH-1:0]              rx_data;
    logic                          rx_err;
    logic                          s_tick;
    logic                          rd_ready;
    logic                          clr_ovr;
    logic                          flush;
    logic                          rd_valid;
    logic [WIDTH-1:0]              rd_data;
    logic                          rd_err;
    logic [count_width(DEPTH)-1:0] count;
    logic                          full;
    logic                          overrun;
    logic                          thresh_irq;
    logic                          timeout_irq;

    // Driver side: receiver strobes, consumer handshake and control.
    modport master (
        output rx_done, rx_data, rx_err, s_tick, rd_ready, clr_ovr, flush,
        input  rd_valid, rd_data, rd_err, count, full, overrun, thresh_irq, timeout_irq
    );

    // FIFO side.
    modport slave (
        input  rx_done, rx_data, rx_err, s_tick, rd_ready, clr_ovr, flush,
        output rd_valid, rd_data, rd_err, count, full, overrun, thresh_irq, timeout_irq
    );
endinterface

// File: rtl/uart_rx_fifo_timeout.sv
// Saturating idle-tick counter and registered character-timeout interrupt.
module uart_rx_fifo_timeout #(
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,          // push, pop, flush or FIFO empty this cycle
    input  logic s_tick,
    input  logic nonempty_next,  // FIFO will hold data after this edge
    output logic timeout_irq
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_TICKS);

    logic [TW-1:0] idle_reg;
    logic [TW-1:0] idle_next;
    logic          irq_reg;

    // Next idle count: restart on activity, otherwise count ticks up to the limit.
    always_comb begin
        idle_next = idle_reg;
        if (clear) begin
            idle_next = '0;
        end else if (s_tick && (idle_reg != LIMIT)) begin
            idle_next = idle_reg + TW'(1);
        end
    end

    // Interrupt is computed from the next state so it rises the cycle after the limiting tick.
    always_ff @(posedge clk) begin
        if (srst) begin
            idle_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            idle_reg <= idle_next;
            irq_reg  <= (idle_next == LIMIT) && nonempty_next;
        end
    end

    assign timeout_irq = irq_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO with show-ahead read port, overrun flag and level/timeout interrupts.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH         = RX_FIFO_DEPTH,
    parameter int WIDTH         = RX_FIFO_WIDTH,
    parameter int THRESH        = RX_FIFO_THRESH,
    parameter int TIMEOUT_TICKS = RX_TIMEOUT_TICKS
) (
    input  logic          clk,
    input  logic          rstN,   // synchronous, active-high
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    logic [WIDTH:0]  mem [DEPTH];
    logic [WIDTH:0]  head;

    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            full_reg, full_next;
    logic            thresh_reg, thresh_next;
    logic            overrun_reg, overrun_next;
    logic            pop, push, drop, tmo_clear;

    // Handshake decode and next-state for pointers, occupancy and flags.
    always_comb begin
        pop  = (count_reg != '0) && bus.rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push = bus.rx_done && (!full_reg || pop);
        // A byte arriving during flush is discarded by the flush, not counted as overrun.
        drop = bus.rx_done && full_reg && !pop && !bus.flush;

        if (bus.flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
            rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
            count_next  = count_reg + CW'(push) - CW'(pop);
        end

        full_next    = (count_next == DEPTH_C);
        thresh_next  = (count_next >= THRESH_C);
        // Set wins over clear when both happen together.
        overrun_next = drop ? 1'b1 : (bus.clr_ovr ? 1'b0 : overrun_reg);
        tmo_clear    = push || pop || bus.flush || (count_reg == '0);
    end

    // Control state; flags are registered alongside the count they summarise.
    always_ff @(posedge clk) begin
        if (rstN) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            thresh_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            full_reg    <= full_next;
            thresh_reg  <= thresh_next;
            overrun_reg <= overrun_next;
        end
    end

    // Entry storage; contents are never reset.
    always_ff @(posedge clk) begin
        if (!rstN && push && !bus.flush) begin
            mem[wr_ptr_reg] <= {bus.rx_err, bus.rx_data};
        end
    end

    uart_rx_fifo_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk           (clk),
        .srst          (rstN),
        .clear         (tmo_clear),
        .s_tick        (bus.s_tick),
        .nonempty_next (count_next != '0),
        .timeout_irq   (bus.timeout_irq)
    );

    // Show-ahead read of the head entry.
    assign head         = mem[rd_ptr_reg];
    assign bus.rd_data  = head[WIDTH-1:0];
    assign bus.rd_err   = head[WIDTH];
    assign bus.rd_valid = (count_reg != '0);
    assign bus.count    = count_reg;
    assign bus.full     = full_reg;
    assign bus.thresh_irq = thresh_reg;
    assign bus.overrun  = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int THRESH = 8;
    localparam int TMO    = 640;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DEPTH(DEPTH), .WIDTH(8), .THRESH(THRESH), .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk  (clk),
        .rstN (rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit model_live = 1'b0;

    // Reference model: FIFO contents, overrun flag, idle tick count, expected timeout irq.
    logic [8:0] q[$];
    bit         m_ovr = 1'b0;
    int         m_idle = 0;
    bit         m_tmo = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic done, input logic [7:0] d, input logic e, input logic rdy,
                       input logic tick, input logic clr, input logic fl, input logic r);
        bus.rx_done  = done;
        bus.rx_data  = d;
        bus.rx_err   = e;
        bus.rd_ready = rdy;
        bus.s_tick   = tick;
        bus.clr_ovr  = clr;
        bus.flush    = fl;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor/scoreboard: compare outputs with the model, pop on handshakes, then advance the model.
    always @(negedge clk) begin
        if (model_live) begin
            int  sz;
            bit  pop, push_ok, drop;
            sz = q.size();
            chk("rd_valid", 32'(bus.rd_valid), 32'(sz != 0));
            chk("count", 32'(bus.count), 32'(sz));
            chk("full", 32'(bus.full), 32'(sz == DEPTH));
            chk("thresh_irq", 32'(bus.thresh_irq), 32'(sz >= THRESH));
            chk("overrun", 32'(bus.overrun), 32'(m_ovr));
            chk("timeout_irq", 32'(bus.timeout_irq), 32'(m_tmo));

            if (rst) begin
                q.delete();
                m_ovr  = 1'b0;
                m_idle = 0;
                m_tmo  = 1'b0;
            end else if (bus.flush) begin
                q.delete();
                m_idle = 0;
                m_tmo  = 1'b0;
                if (bus.clr_ovr) m_ovr = 1'b0;
            end else begin
                pop     = (sz != 0) && bus.rd_ready;
                push_ok = bus.rx_done && ((sz < DEPTH) || pop);
                drop    = bus.rx_done && !push_ok;
                if (pop) begin
                    logic [8:0] exp_e;
                    exp_e = q.pop_front();
                    chk("pop_entry", 32'({bus.rd_err, bus.rd_data}), 32'(exp_e));
                    $display("POP  data=%02h err=%b expected data=%02h err=%b",
                             bus.rd_data, bus.rd_err, exp_e[7:0], exp_e[8]);
                end
                if (push_ok) q.push_back({bus.rx_err, bus.rx_data});
                if (drop) begin
                    m_ovr = 1'b1;
                    $display("DROP data=%02h (fifo full)", bus.rx_data);
                end else if (bus.clr_ovr) begin
                    m_ovr = 1'b0;
                end
                if (push_ok || pop || sz == 0) m_idle = 0;
                else if (bus.s_tick && m_idle < TMO) m_idle++;
                m_tmo = (m_idle == TMO) && (q.size() != 0);
            end
        end
    end

    // Head of a non-empty FIFO must always be presented on the read port.
    always @(negedge clk) begin
        if (model_live && !rst && q.size() != 0) begin
            chk("head", 32'({bus.rd_err, bus.rd_data}), 32'(q[0]));
        end
    end

    // Stimulus.
    initial begin
        bus.rx_done = 1'b0; bus.rx_data = '0; bus.rx_err = 1'b0; bus.s_tick = 1'b0;
        bus.rd_ready = 1'b0; bus.clr_ovr = 1'b0; bus.flush = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        model_live = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        // Single byte in and out.
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Fill, drain, refill across the pointer wrap.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overrun on a full FIFO, then clear it.
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // Push and pop together while full.
        cyc(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Error tag and character timeout.
        cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TMO + 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        // Set overrun, then flush with a simultaneous push: overrun survives.
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        // Reset mid-fill with a simultaneous push.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h70 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        // Random traffic in alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 250; i++) begin
                logic done, rdy, tick, clr, fl, r;
                done = ($urandom_range(99) < ((ph % 2 == 0) ? 75 : 30));
                rdy  = ($urandom_range(99) < ((ph % 2 == 0) ? 30 : 75));
                tick = ($urandom_range(3) == 0);
                clr  = ($urandom_range(49) == 0);
                fl   = ($urandom_range(199) == 0);
                r    = ($urandom_range(499) == 0);
                cyc(done, 8'($urandom), 1'($urandom), rdy, tick, clr, fl, r);
            end
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
